instr_fetch_unit: RTL and testbench

Instruction fetch stage of the R/I-type MIPS CPU, directly upstream of the instruction decoder. Holds the program counter, requests instruction words from instruction memory over a req/ack handshake, latches each word in an instruction register, and presents the split fields (op, rs, rt, rd, shamt, func, imm) to the decoder and register-file read ports under a valid/ready handshake. A reserved halt word stops fetching until reset.

---
 rtl/ifetch_pkg.sv | 40 ++++
 rtl/instr_fields.sv | 36 +++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifetch_pkg                                                    |
// | Purpose  : Shared definitions for the instruction fetch stage: FSM state |
// |            encoding, instruction field positions/widths and the default  |
// |            halt word.                                                    |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ifetch_pkg;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } ifetch_state_t;

  // Instruction field positions (LSB) and widths
  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SH_W    = 5;
  localparam int FN_W    = 6;
  localparam int IMM_W   = 16;

  localparam int INSTR_W = 32;

  // Reserved word that stops fetching until reset
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/instr_fields.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fields                                                  |
// | Purpose  : Purely combinational splitter of a 32-bit R/I-type MIPS word  |
// |            into its fields. Reusable by the decoder testbench.           |
// | Ports    : ir_i      - instruction word                                  |
// |            op_o      - ir[31:26]     rs_o    - ir[25:21]                 |
// |            rt_o      - ir[20:16]     rd_o    - ir[15:11]                 |
// |            shamt_o   - ir[10:6]      func_o  - ir[5:0]                   |
// |            imm_o     - ir[15:0]                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_fields
  import ifetch_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output logic [OP_W-1:0]    op_o,
  output logic [REG_W-1:0]   rs_o,
  output logic [REG_W-1:0]   rt_o,
  output logic [REG_W-1:0]   rd_o,
  output logic [SH_W-1:0]    shamt_o,
  output logic [FN_W-1:0]    func_o,
  output logic [IMM_W-1:0]   imm_o
);

  assign op_o    = ir_i[OP_LSB  +: OP_W];
  assign rs_o    = ir_i[RS_LSB  +: REG_W];
  assign rt_o    = ir_i[RT_LSB  +: REG_W];
  assign rd_o    = ir_i[RD_LSB  +: REG_W];
  assign shamt_o = ir_i[SH_LSB  +: SH_W];
  assign func_o  = ir_i[FN_LSB  +: FN_W];
  // imm overlaps rd/shamt/func; I-type and R-type views of the same bits
  assign imm_o   = ir_i[IMM_LSB +: IMM_W];

endmodule : instr_fields
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                              |
// | Purpose  : Instruction fetch stage. Holds the PC, fetches words from     |
// |            instruction memory over a req/ack handshake, latches them in  |
// |            the IR and hands them downstream over valid/ready. The halt   |
// |            word stops fetching until reset.                              |
// | Ports    : clk, rst          - clock, async active-high reset            |
// |            imem_req/addr     - fetch request, word address              |
// |            imem_ack/rdata    - memory data valid, instruction word      |
// |            ir_valid/ir_ready - downstream handshake                     |
// |            ir, op..imm       - instruction register and its fields      |
// |            pc                - address of IR / pending fetch            |
// |            halted            - halt state reached                       |
// |            instr_cnt         - retired-instruction count                |
// | Config   : IFETCH_INSTR_CNT_EN - when defined, builds the 32-bit retire  |
// |            counter; otherwise instr_cnt is tied to zero.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  IMEM_AW   = 6,
  parameter logic [31:0]         HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [31:0]         ir,
  output logic [5:0]          op,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          func,
  output logic [15:0]         imm,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic [31:0]         instr_cnt
);

  localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(4);

  ifetch_state_t       state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;

  // State, PC and IR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic. The handshake inputs only steer registers, so no
  // combinational path exists from imem_ack/ir_ready to any output.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = (imem_rdata == HALT_WORD) ? HALT : VALID;
        end
      end
      VALID: begin
        if (ir_ready) begin
          // Modulo 2^PC_WIDTH by construction of the register width
          pc_d    = pc_q + C_PC_STEP;
          state_d = FETCH;
        end
      end
      HALT: begin
        // Sticky until reset; acks and ready pulses are ignored
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Moore outputs
  assign imem_req  = (state_q == FETCH);
  assign ir_valid  = (state_q == VALID);
  assign halted    = (state_q == HALT);
  // Word address; wraps silently by truncation of the upper PC bits
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign ir        = ir_q;

`ifdef IFETCH_INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == VALID) && ir_ready) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

  instr_fields u_fields (
    .ir_i    (ir_q),
    .op_o    (op),
    .rs_o    (rs),
    .rt_o    (rt),
    .rd_o    (rd),
    .shamt_o (shamt),
    .func_o  (func),
    .imm_o   (imm)
  );

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                           |
// | Purpose  : Self-checking bench for instr_fetch_unit. A per-cycle vector  |
// |            table covers a three-word program ending in the halt word;    |
// |            hand-written sequences cover field slicing, delayed acks with |
// |            stalled ready, reset during a pending fetch and PC wrap.      |
// | Config   : IFETCH_INSTR_CNT_EN selects the expected instr_cnt values.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] instr_cnt;

  // Wrap DUT (RESET_PC = 32'hFFFF_FFFC)
  logic        w_req;
  logic [5:0]  w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_ir;
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [5:0]  w_func;
  logic [15:0] w_imm;
  logic [31:0] w_pc;
  logic        w_halted;
  logic [31:0] w_cnt;

  logic [31:0] mem [64];
  int          ack_delay;
  logic        force_ack;
  int          wcnt;

  int checks = 0;
  int errors = 0;

  assign imem_rdata = mem[imem_addr];
  assign w_ack      = ~rst;
  assign w_rdata    = 32'h0000_0000;

  instr_fetch_unit u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir         (ir),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .func       (func),
    .imm        (imm),
    .pc         (pc),
    .halted     (halted),
    .instr_cnt  (instr_cnt)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_ack   (w_ack),
    .imem_rdata (w_rdata),
    .ir_valid   (w_valid),
    .ir_ready   (w_ready),
    .ir         (w_ir),
    .op         (w_op),
    .rs         (w_rs),
    .rt         (w_rt),
    .rd         (w_rd),
    .shamt      (w_shamt),
    .func       (w_func),
    .imm        (w_imm),
    .pc         (w_pc),
    .halted     (w_halted),
    .instr_cnt  (w_cnt)
  );

  // Memory model: ack arrives ack_delay cycles after req first rises;
  // during reset only force_ack can drive it (to model a stray late ack).
  initial begin
    imem_ack = 1'b0;
    wcnt     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ack = force_ack;
        wcnt     = 0;
      end else if (imem_req) begin
        imem_ack = (wcnt >= ack_delay);
        wcnt     = imem_ack ? 0 : wcnt + 1;
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef IFETCH_INSTR_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Async assert mid-cycle, release 2 cycles later just after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic        valid;
    logic        hlt;
    logic [31:0] pc;
    logic [31:0] ir;
    int          nret;
  } vec_t;

  vec_t tbl [9];

  localparam logic [31:0] ADDI = 32'h2001_0005; // addi $1,$0,5
  localparam logic [31:0] ADDR = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] HLTW = 32'hFFFF_FFFF;

  initial begin
    // Per-cycle program trace, cycle 1 = first cycle after reset release
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 0};  // fetch word 0
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, ADDI,  0};  // addi valid, stalled
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, ADDI,  0};  // consumed
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd4, ADDI,  1};  // ready ignored in FETCH
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd4, ADDR,  1};  // add valid and consumed
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd8, ADDR,  2};  // fetch halt word
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd8, HLTW,  2};  // halted, ready ignored
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd8, HLTW,  2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd8, HLTW,  2};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = ADDI;
    mem[1] = ADDR;
    mem[2] = HLTW;

    rst       = 1'b0;
    ir_ready  = 1'b0;
    w_ready   = 1'b0;
    force_ack = 1'b0;
    ack_delay = 0;

    // Reset state (imem_req is combinational from state, so high in reset)
    #1 rst = 1'b1;
    #1;
    chk("rst_req",    {31'b0, imem_req}, 32'd1);
    chk("rst_valid",  {31'b0, ir_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted},   32'd0);
    chk("rst_pc",     pc,                32'd0);
    chk("rst_ir",     ir,                32'd0);
    chk("rst_cnt",    instr_cnt,         32'd0);
    chk("rst_wpc",    w_pc,              32'hFFFF_FFFC);

    do_reset();

    // Table-driven program run through HALT
    for (int i = 0; i < 9; i++) begin
      ir_ready = tbl[i].ready;
      chk($sformatf("tbl%0d_req", i),    {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("tbl%0d_valid", i),  {31'b0, ir_valid}, {31'b0, tbl[i].valid});
      chk($sformatf("tbl%0d_halted", i), {31'b0, halted},   {31'b0, tbl[i].hlt});
      chk($sformatf("tbl%0d_pc", i),     pc,                tbl[i].pc);
      chk($sformatf("tbl%0d_addr", i),   {26'b0, imem_addr}, {26'b0, tbl[i].pc[7:2]});
      chk($sformatf("tbl%0d_ir", i),     ir,                tbl[i].ir);
      chk($sformatf("tbl%0d_op", i),     {26'b0, op},       {26'b0, tbl[i].ir[31:26]});
      chk($sformatf("tbl%0d_imm", i),    {16'b0, imm},      {16'b0, tbl[i].ir[15:0]});
      chk($sformatf("tbl%0d_cnt", i),    instr_cnt,         exp_cnt(tbl[i].nret));
      step();
    end
    ir_ready = 1'b0;

    // R-type field slicing
    mem[0] = ADDR;
    do_reset();
    step();
    chk("rtype_valid", {31'b0, ir_valid}, 32'd1);
    chk("rtype_op",    {26'b0, op},    32'd0);
    chk("rtype_rs",    {27'b0, rs},    32'd1);
    chk("rtype_rt",    {27'b0, rt},    32'd2);
    chk("rtype_rd",    {27'b0, rd},    32'd3);
    chk("rtype_shamt", {27'b0, shamt}, 32'd0);
    chk("rtype_func",  {26'b0, func},  32'h20);
    mem[0] = ADDI;

    // Ack 3 cycles after req, ready held low 4 cycles in VALID
    ack_delay = 3;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("dly_c%0d_req", c),   {31'b0, imem_req}, 32'd1);
      chk($sformatf("dly_c%0d_addr", c),  {26'b0, imem_addr}, 32'd0);
      chk($sformatf("dly_c%0d_valid", c), {31'b0, ir_valid}, 32'd0);
      step();
    end
    for (int c = 5; c <= 9; c++) begin
      ir_ready = (c == 9);
      chk($sformatf("dly_c%0d_valid", c), {31'b0, ir_valid}, 32'd1);
      chk($sformatf("dly_c%0d_ir", c),    ir,        ADDI);
      chk($sformatf("dly_c%0d_pc", c),    pc,        32'd0);
      chk($sformatf("dly_c%0d_cnt", c),   instr_cnt, 32'd0);
      step();
    end
    ir_ready = 1'b0;
    chk("dly_after_pc",   pc,                 32'd4);
    chk("dly_after_req",  {31'b0, imem_req},  32'd1);
    chk("dly_after_addr", {26'b0, imem_addr}, 32'd1);
    chk("dly_after_cnt",  instr_cnt,          exp_cnt(1));

    // Reset while the fetch at pc=4 waits for its delayed ack
    #1;
    rst       = 1'b1;
    force_ack = 1'b1;
    #1;
    chk("rstmid_pc",    pc,                32'd0);
    chk("rstmid_ir",    ir,                32'd0);
    chk("rstmid_valid", {31'b0, ir_valid}, 32'd0);
    chk("rstmid_req",   {31'b0, imem_req}, 32'd1);
    chk("rstmid_cnt",   instr_cnt,         32'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rstack_ir",    ir,                32'd0);
    chk("rstack_valid", {31'b0, ir_valid}, 32'd0);
    force_ack = 1'b0;
    rst       = 1'b0;
    chk("rstrel_pc",    pc,                 32'd0);
    chk("rstrel_addr",  {26'b0, imem_addr}, 32'd0);
    chk("rstrel_req",   {31'b0, imem_req},  32'd1);
    ack_delay = 0;

    // PC wrap on the second instance
    do_reset();
    chk("wrap_pc0",   w_pc,            32'hFFFF_FFFC);
    chk("wrap_addr0", {26'b0, w_addr}, 32'h3F);
    chk("wrap_req0",  {31'b0, w_req},  32'd1);
    step();
    chk("wrap_valid", {31'b0, w_valid}, 32'd1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("wrap_pc1",   w_pc,            32'd0);
    chk("wrap_addr1", {26'b0, w_addr}, 32'd0);
    chk("wrap_req1",  {31'b0, w_req},  32'd1);
    chk("wrap_cnt",   w_cnt,           exp_cnt(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
